// File: rtl/data_mem_io_if.sv
// CPU data-side control bus plus the TX FIFO valid/ready drain port.
// The bidirectional data bus stays a module port so it can be resolved as a tristate net.
interface data_mem_io_if;
   logic [63:0] DAB;
   logic        MemWrite;
   logic        MemRead;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      output DAB, MemWrite, MemRead, tx_ready,
      input  tx_data, tx_valid
   );

   modport slave (
      input  DAB, MemWrite, MemRead, tx_ready,
      output tx_data, tx_valid
   );
endinterface

// File: rtl/data_mem_io.sv
// LEGv8 data-side memory: 64-bit RAM plus an I/O page holding a TX FIFO and a cycle counter.
// Reads are combinational onto DDB; all writes commit on the rising edge.
module data_mem_io #(
   parameter int unsigned RAM_WORDS  = 256,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [63:0] IO_BASE    = 64'hFFFF_FFFF_FFFF_0000
) (
   input  logic         clk,
   input  logic         rst,
   data_mem_io_if.slave bus,
   inout  wire  [63:0]  DDB,
   output logic         bus_err
);
   localparam int unsigned AW = $clog2(RAM_WORDS);
   localparam int unsigned PW = $clog2(FIFO_DEPTH);

   logic [63:0]   ram [RAM_WORDS];
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [PW:0]   count;
   logic          ovf;
   logic [63:0]   cycle;

   logic          rd_ok, wr_ok, both;
   logic          ram_sel, io_sel;
   logic [AW-1:0] ram_idx;
   logic [1:0]    io_off;
   logic          full, empty, pop, push, push_ok;
   logic [3:0]    cnt4;
   logic [63:0]   status, rd_data;
   logic          ram_we, cyc_we, ovf_clr, err_clr, err_set;
   logic          unused_bits;

   assign rd_ok   = bus.MemRead && !bus.MemWrite;
   assign wr_ok   = bus.MemWrite && !bus.MemRead;
   assign both    = bus.MemRead && bus.MemWrite;
   assign ram_sel = (bus.DAB[63:AW+3] == '0);
   assign io_sel  = (bus.DAB[63:5] == IO_BASE[63:5]);
   assign ram_idx = bus.DAB[AW+2:3];
   assign io_off  = bus.DAB[4:3];
   assign unused_bits = ^bus.DAB[2:0];

   assign full  = (count == (PW+1)'(FIFO_DEPTH));
   assign empty = (count == '0);
   assign pop   = !empty && bus.tx_ready;
   assign push_ok = push && (!full || pop);

   assign bus.tx_valid = !empty;
   assign bus.tx_data  = fifo_mem[rd_ptr];

   always_comb begin
      if (32'(count) > 32'd15) cnt4 = 4'hF;
      else                     cnt4 = 4'(count);
   end

   assign status = {56'b0, cnt4, ovf, 1'b0, empty, full};

   // Address decode: one place produces both the read mux and every write strobe.
   always_comb begin
      rd_data = '0;
      ram_we  = 1'b0;
      push    = 1'b0;
      cyc_we  = 1'b0;
      ovf_clr = 1'b0;
      err_clr = 1'b0;
      err_set = both;
      if (ram_sel) begin
         rd_data = ram[ram_idx];
         ram_we  = wr_ok;
      end else if (io_sel) begin
         case (io_off)
            2'd0: push = wr_ok;
            2'd1: begin
               rd_data = status;
               ovf_clr = wr_ok && DDB[3];
               err_clr = wr_ok && DDB[4];
            end
            2'd2: begin
               rd_data = cycle;
               cyc_we  = wr_ok;
            end
            default: ;
         endcase
      end else if (bus.MemRead || bus.MemWrite) begin
         err_set = 1'b1;
      end
   end

   assign DDB = rd_ok ? rd_data : 'z;

   always_ff @(posedge clk) begin
      if (!rst && ram_we) ram[ram_idx] <= DDB;
   end

   always_ff @(posedge clk) begin
      if (!rst && push_ok) fifo_mem[wr_ptr] <= DDB[7:0];
   end

   // Sticky flags: a set wins over a clear in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         ovf     <= 1'b0;
         bus_err <= 1'b0;
         cycle   <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && full && !pop) ovf <= 1'b1;
         else if (ovf_clr)         ovf <= 1'b0;
         if (err_set)      bus_err <= 1'b1;
         else if (err_clr) bus_err <= 1'b0;
         cycle <= cyc_we ? DDB : cycle + 64'd1;
      end
   end
endmodule

// File: doc/data_mem_io.md
# data_mem_io

Data-side memory subsystem that sits directly downstream of the single-cycle LEGv8 CPU's data bus. It consumes the CPU's data address bus, bidirectional data bus, MemWrite and MemRead. It serves a local 64-bit RAM plus a small memory-mapped I/O page: an 8-bit transmit FIFO with a valid/ready drain port, and a loadable free-running cycle counter. Reads are combinational so a load completes in the CPU's single cycle; writes commit on the rising clock edge.

## Interface
- `RAM_WORDS`, 256: RAM depth in 64-bit doublewords (power of two).
- `FIFO_DEPTH`, 8: TX FIFO entries (power of two, ≥2).
- `IO_BASE`, 64'hFFFF_FFFF_FFFF_0000: base byte address of the I/O page.

- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `DAB`  in  64: data address bus, byte address.
- `DDB`  inout  64: data bus. The block drives it only during a legal read; otherwise it is high-Z.
- `MemWrite`  in  1: CPU store strobe.
- `MemRead`  in  1: CPU load strobe.
- `tx_data`  out  8: FIFO head byte.
- `tx_valid`  out  1: FIFO not empty.
- `tx_ready`  in  1: sink accepts `tx_data` this cycle.
- `bus_err`  out  1: sticky error flag.

## Operation
- Access classes:
  - Legal read: `MemRead && !MemWrite`.
  - Legal write: `MemWrite && !MemRead`.
  - Both high: illegal. `DDB` stays Z, nothing is written, `bus_err` is set.
- RAM region:
  - Covers `DAB < RAM_WORDS*8`.
  - Index is `DAB[log2(RAM_WORDS)+2:3]`; `DAB[2:0]` is ignored (doubleword access only).
- I/O page, selected by `DAB[63:5] == IO_BASE[63:5]`; offsets are `DAB[4:3]`:
  - 0 TXDATA:
    - Write pushes `DDB[7:0]`.
    - Read returns 0.
  - 1 STATUS:
    - Read returns {56'b0, count[3:0], ovf, 1'b0, empty, full}, with bit0=full, bit1=empty, bit3=ovf, bits[7:4]=count. `count` saturates at its 4-bit width.
    - Write with `DDB[3]=1` clears `ovf`.
    - Writing 1 to `DDB[4]` clears `bus_err`.
  - 2 CYCLE:
    - Read returns the counter.
    - Write loads the counter with `DDB`.
  - 3: reads return 0; writes are ignored without error.
- Unmapped address (neither region): reads return 0, writes are ignored, and `bus_err` is set.
- FIFO:
  - Circular buffer with rd/wr pointers and a count register.
  - Push is accepted iff `!full || pop`.
  - Pop occurs when `tx_valid && tx_ready`.
  - Simultaneous push and pop on a full FIFO keeps count at `FIFO_DEPTH`.
  - Push on full without pop drops the byte and sets `ovf`.
  - Pop on empty does nothing.
  - Pointers wrap modulo `FIFO_DEPTH`.
- Cycle counter:
  - 64-bit; increments by 1 every cycle and wraps from 2^64-1 to 0.
  - A CYCLE write overrides the increment in that cycle.
- Sticky flags (`ovf`, `bus_err`): a set and a clear in the same cycle resolves as set.

## Timing
- Reset (`rst` high at an edge):
  - FIFO empty, pointers and count 0.
  - `tx_valid`=0.
  - Counter 0.
  - `ovf`=0, `bus_err`=0.
  - RAM contents are unchanged and undefined after power-up.
  - `tx_data` is don't-care while `tx_valid`=0.
- Reset mid-operation discards FIFO contents and any write presented in that cycle.
- `DDB` may be driven during reset if a legal read is presented, but the value is don't-care.
- Read latency 0: `DDB` is combinational from `DAB`/`MemRead` and reflects pre-edge state. A STATUS read in a push cycle shows the old count.
- Write latency 1 edge: a read in the following cycle sees the new value.
- `tx_valid` and `tx_data` are registered-state derived, so a pushed byte appears on `tx_data` the cycle after the push edge.
- A CYCLE read returns the registered value. After a write of W, reads return W, W+1, ... on subsequent cycles.
- A single-entry FIFO that is popped and pushed in the same cycle presents the new byte next cycle with `tx_valid` still 1.

## Test plan
- Reset, then read CYCLE on 3 consecutive cycles → 0, 1, 2. Read STATUS → 0x02 (empty).
- RAM: write 64'hDEAD_BEEF_0123_4567 to 0x10, read 0x10 next cycle → same value. Read 0x17 → same value (low bits ignored). `DDB` is Z when neither strobe is high.
- FIFO with `tx_ready`=0:
  - Push 0x41..0x48 → STATUS = 0x81 (count 8, full).
  - Push 0x49 → `ovf` set, STATUS = 0x89.
  - Raise `tx_ready` → drains 0x41..0x48 in order, `tx_valid` drops after the 8th byte, and 0x49 never appears.
- Full FIFO, push 0x55 with `tx_ready`=1 in the same cycle → count stays 8, no `ovf`. 0x55 emerges after the 7 remaining bytes.
- Write to address 0x1_0000 (unmapped) → `bus_err`=1, RAM unchanged. Assert both strobes → `DDB` Z and no write. Write STATUS with 0x18 → `bus_err`=0, `ovf`=0.
- Write 64'hFFFF_FFFF_FFFF_FFFE to CYCLE → subsequent reads return ...FFFE, ...FFFF, 0. Assert `rst` mid-drain → `tx_valid`=0 and counter 0 on the next cycle.
